npc_sequencer: RTL

- Next-PC controller for the single-issue MIPS-style core.
- Owns the PC register and sequences instruction fetch over a req/ack handshake.
- Forms J/JAL targets from the 26-bit instruction index, shifted left 2 and joined with the upper 4 PC bits. Forms branch and JR targets.
- Applies redirects after the architectural delay slot; sits between decode and the instruction-memory port.

---
 rtl/npc_sequencer_pkg.sv | 18 +
 rtl/npc_target_calc.sv | 51 +++++
 rtl/npc_sequencer.sv | 114 +++++++++++
 3 files changed

// File: rtl/npc_sequencer_pkg.sv
// Shared types and constants for the next-PC sequencer.
// Control-transfer encodings, FSM states and reset defaults.
package npc_sequencer_pkg;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;

    localparam logic [1:0] CT_J   = 2'b00;
    localparam logic [1:0] CT_JR  = 2'b01;
    localparam logic [1:0] CT_BR  = 2'b10;
    localparam logic [1:0] CT_RSV = 2'b11;

    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        FETCH = 2'b01,
        HOLD  = 2'b10
    } state_e;

endpackage

// File: rtl/npc_target_calc.sv
// Combinational redirect target formation for J, JR and branches.
// Targets are relative to the delay-slot address ctl_pc + 4.
module npc_target_calc
    import npc_sequencer_pkg::*;
(
    input  logic [1:0]  ctl_type_i,
    input  logic [31:0] ctl_pc_i,
    input  logic [25:0] instr_index_i,
    input  logic [15:0] br_offset_i,
    input  logic        br_taken_i,
    input  logic [31:0] jr_target_i,
    output logic [31:0] target_o,
    output logic        take_o,
    output logic        misaligned_o
);

    logic [31:0] ds;
    logic [31:0] br_off;

    assign ds     = ctl_pc_i + 32'd4;
    assign br_off = {{14{br_offset_i[15]}}, br_offset_i, 2'b00};

    // Select target per transfer type; JR low bits are forced to a word boundary
    always_comb begin
        target_o     = ds;
        take_o       = 1'b0;
        misaligned_o = 1'b0;
        unique case (ctl_type_i)
            CT_J: begin
                target_o = {ds[31:28], instr_index_i, 2'b00};
                take_o   = 1'b1;
            end
            CT_JR: begin
                target_o     = {jr_target_i[31:2], 2'b00};
                take_o       = 1'b1;
                misaligned_o = |jr_target_i[1:0];
            end
            CT_BR: begin
                target_o = ds + br_off;
                take_o   = br_taken_i;
            end
            CT_RSV: begin
                take_o = 1'b0;
            end
            default: begin
                take_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/npc_sequencer.sv
// Next-PC controller: owns the PC and sequences instruction fetch.
// Redirects take effect after the delay-slot fetch completes.
module npc_sequencer
    import npc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter int          ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic              stall,
    input  logic              ctl_valid,
    input  logic [1:0]        ctl_type,
    input  logic [ADDR_W-1:0] ctl_pc,
    input  logic [25:0]       instr_index,
    input  logic [15:0]       br_offset,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] jr_target,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              redirect_pending,
    output logic              misalign_err
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic              pend_q, pend_d;
    logic              mis_q, mis_d;

    logic [ADDR_W-1:0] calc_tgt;
    logic              calc_take;
    logic              calc_mis;
    logic              advance;
    logic              capture;

    npc_target_calc u_calc (
        .ctl_type_i    (ctl_type),
        .ctl_pc_i      (ctl_pc),
        .instr_index_i (instr_index),
        .br_offset_i   (br_offset),
        .br_taken_i    (br_taken),
        .jr_target_i   (jr_target),
        .target_o      (calc_tgt),
        .take_o        (calc_take),
        .misaligned_o  (calc_mis)
    );

    // Only a transfer sitting just before the current fetch is a real
    // redirect; a second one inside a delay slot is dropped.
    assign capture = ctl_valid && calc_take && !pend_q
                   && (ctl_pc == pc_q - ADDR_W'(4));

    assign advance = ((state_q == FETCH) && imem_ack && !stall)
                   || ((state_q == HOLD) && !stall);

    // Fetch handshake FSM: boot, request, and stall-hold after an ack
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT:    state_d = FETCH;
            FETCH:   if (imem_ack && stall) state_d = HOLD;
            HOLD:    if (!stall) state_d = FETCH;
            default: state_d = BOOT;
        endcase
    end

    // PC select and redirect capture; a same-cycle redirect bypasses capture
    always_comb begin
        pc_d   = pc_q;
        tgt_d  = tgt_q;
        pend_d = pend_q;
        mis_d  = capture && calc_mis;
        if (advance) begin
            pend_d = 1'b0;
            unique case (1'b1)
                pend_q:             pc_d = tgt_q;
                !pend_q && capture: pc_d = calc_tgt;
                default:            pc_d = pc_q + ADDR_W'(4);
            endcase
        end else if (capture) begin
            tgt_d  = calc_tgt;
            pend_d = 1'b1;
        end
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
            tgt_q   <= '0;
            pend_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            pend_q  <= pend_d;
            mis_q   <= mis_d;
        end
    end

    assign imem_req         = (state_q == FETCH);
    assign imem_addr        = pc_q;
    assign pc_out           = pc_q;
    assign pc_plus4         = pc_q + ADDR_W'(4);
    assign redirect_pending = pend_q;
    assign misalign_err     = mis_q;

endmodule
